// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings and constants for the I2C master/slave pair
package i2c_pkg;

  localparam int BIT_CNT_W = 3;
  localparam logic SDA_IDLE = 1'b1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

  typedef enum logic [3:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_ADDR_ACK,
    M_WR_DATA,
    M_WR_ACK,
    M_RD_DATA,
    M_RD_NACK,
    M_STOP
  } master_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_ADDR,
    S_ADDR_ACK,
    S_RECV_DATA,
    S_DATA_ACK,
    S_SEND_DATA,
    S_WAIT_MACK
  } slave_state_t;

endpackage

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - addressed I2C slave, clk-sampled bus with edge detection
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda,
  input  logic       scl,
  input  logic [6:0] slave_addr,
  output logic       sda_drive,
  output logic       ack,
  output logic       new_byte_received,
  output logic [7:0] rx_data
);

  localparam int ACK_W = $clog2(2 * HALF_PERIOD);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(2 * HALF_PERIOD - 1);

  slave_state_t         state;
  logic                 scl_q;
  logic                 sda_q;
  logic [7:0]           sr;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [ACK_W-1:0]     ack_cnt;
  logic                 rd_req;

  logic rise, fall, start_det, stop_det;

  assign rise      = ~scl_q & scl;
  assign fall      = scl_q & ~scl;
  assign start_det = scl_q & scl & sda_q & ~sda;
  assign stop_det  = scl_q & scl & ~sda_q & sda;

  // rx_data doubles as the stored byte returned on reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      scl_q             <= 1'b1;
      sda_q             <= SDA_IDLE;
      sr                <= '0;
      bit_cnt           <= '0;
      ack_cnt           <= '0;
      rd_req            <= 1'b0;
      sda_drive         <= SDA_IDLE;
      ack               <= 1'b0;
      new_byte_received <= 1'b0;
      rx_data           <= '0;
    end else begin
      scl_q             <= scl;
      sda_q             <= sda;
      new_byte_received <= 1'b0;
      if (start_det) begin
        state     <= S_RECV_ADDR;
        bit_cnt   <= '0;
        sda_drive <= SDA_IDLE;
        ack       <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        sda_drive <= SDA_IDLE;
        ack       <= 1'b0;
      end else begin
        case (state)
          S_RECV_ADDR: if (rise) begin
            sr      <= {sr[6:0], sda};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              rd_req <= sda;
              state  <= (sr[6:0] == slave_addr) ? S_ADDR_ACK : S_IDLE;
            end
          end
          S_RECV_DATA: if (rise) begin
            sr      <= {sr[6:0], sda};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              rx_data           <= {sr[6:0], sda};
              new_byte_received <= 1'b1;
              state             <= S_DATA_ACK;
            end
          end
          // ACK is held one full SCL period from the fall that opens the ACK bit;
          // after the data ACK no fall follows, since STOP keeps SCL high.
          S_ADDR_ACK, S_DATA_ACK: begin
            if (!ack) begin
              if (fall) begin
                ack       <= 1'b1;
                sda_drive <= 1'b0;
                ack_cnt   <= '0;
              end
            end else if (fall || ack_cnt == ACK_LAST) begin
              ack       <= 1'b0;
              sda_drive <= SDA_IDLE;
              bit_cnt   <= '0;
              if (state == S_DATA_ACK) begin
                state <= S_IDLE;
              end else if (rd_req) begin
                state     <= S_SEND_DATA;
                sda_drive <= rx_data[7];
                sr        <= {rx_data[6:0], 1'b0};
              end else begin
                state <= S_RECV_DATA;
              end
            end else begin
              ack_cnt <= ack_cnt + 1'b1;
            end
          end
          S_SEND_DATA: if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              sda_drive <= SDA_IDLE;
              state     <= S_WAIT_MACK;
            end else begin
              sda_drive <= sr[7];
              sr        <= {sr[6:0], 1'b0};
            end
          end
          S_WAIT_MACK: if (rise) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_master_slave_pair.sv
// rtl/i2c_master_slave_pair.sv - byte-oriented I2C master looped back onto an addressed slave
module i2c_master_slave_pair
  import i2c_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       rw,
  input  logic       enable,
  input  logic [6:0] slave_addr,
  output logic [7:0] data_out,
  output logic       ready,
  output logic [7:0] rx_data,
  output logic       new_byte_received,
  output logic       ack,
  output logic       i2c_sda,
  output logic       i2c_scl
);

  localparam int PERIOD = 2 * HALF_PERIOD;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  master_state_t        state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shreg;
  logic [7:0]           data_l;
  logic                 rw_l;
  logic                 nack;
  logic                 scl_m;
  logic                 sda_m;
  logic                 sda_s;
  logic                 second_half;

  assign second_half = (cnt >= CNT_HALF);
  assign i2c_sda     = sda_m & sda_s;
  assign i2c_scl     = scl_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= M_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_l   <= '0;
      rw_l     <= 1'b0;
      nack     <= 1'b0;
      data_out <= '0;
      ready    <= 1'b1;
      scl_m    <= 1'b1;
      sda_m    <= SDA_IDLE;
    end else begin
      case (state)
        M_IDLE:            begin scl_m <= 1'b1;        sda_m <= SDA_IDLE;     end
        M_START:           begin scl_m <= 1'b1;        sda_m <= ~second_half; end
        M_STOP:            begin scl_m <= 1'b1;        sda_m <= second_half;  end
        M_ADDR, M_WR_DATA: begin scl_m <= second_half; sda_m <= shreg[7];     end
        default:           begin scl_m <= second_half; sda_m <= SDA_IDLE;     end
      endcase

      if (state == M_IDLE) begin
        cnt <= '0;
        if (enable) begin
          shreg  <= {addr, rw};
          data_l <= data_in;
          rw_l   <= rw;
          ready  <= 1'b0;
          state  <= M_START;
        end
      end else begin
        // Mid-period sample lines up with the SCL rising edge on the bus.
        if (cnt == CNT_HALF) begin
          if (state == M_ADDR_ACK || state == M_WR_ACK) nack <= i2c_sda;
          if (state == M_RD_DATA) begin
            shreg <= {shreg[6:0], i2c_sda};
            if (bit_cnt == LAST_BIT) data_out <= {shreg[6:0], i2c_sda};
          end
        end
        if (cnt != CNT_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          case (state)
            M_START: state <= M_ADDR;
            M_ADDR: begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {shreg[6:0], 1'b0};
              if (bit_cnt == LAST_BIT) state <= M_ADDR_ACK;
            end
            M_ADDR_ACK: begin
              if (nack) begin
                state <= M_STOP;
              end else if (rw_l) begin
                state <= M_RD_DATA;
              end else begin
                state <= M_WR_DATA;
                shreg <= data_l;
              end
            end
            M_WR_DATA: begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {shreg[6:0], 1'b0};
              if (bit_cnt == LAST_BIT) state <= M_WR_ACK;
            end
            M_WR_ACK: state <= M_STOP;
            M_RD_DATA: begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= M_RD_NACK;
            end
            M_RD_NACK: state <= M_STOP;
            M_STOP: begin
              state <= M_IDLE;
              ready <= 1'b1;
            end
            default: state <= M_IDLE;
          endcase
        end
      end
    end
  end

  i2c_slave_ctrl #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_slave (
    .clk              (clk),
    .rst              (rst),
    .sda              (i2c_sda),
    .scl              (i2c_scl),
    .slave_addr       (slave_addr),
    .sda_drive        (sda_s),
    .ack              (ack),
    .new_byte_received(new_byte_received),
    .rx_data          (rx_data)
  );

endmodule

// File: tb/tb_i2c_master_slave_pair.sv
// tb/tb_i2c_master_slave_pair.sv - randomized self-checking bench for the I2C master/slave pair
module tb_i2c_master_slave_pair;

  localparam int HP = 2;
  localparam logic [6:0] SLV = 7'h2A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       rw = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] slave_addr = SLV;
  logic [7:0] data_out;
  logic       ready;
  logic [7:0] rx_data;
  logic       new_byte_received;
  logic       ack;
  logic       i2c_sda;
  logic       i2c_scl;

  i2c_master_slave_pair #(.HALF_PERIOD(HP)) dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .data_in          (data_in),
    .rw               (rw),
    .enable           (enable),
    .slave_addr       (slave_addr),
    .data_out         (data_out),
    .ready            (ready),
    .rx_data          (rx_data),
    .new_byte_received(new_byte_received),
    .ack              (ack),
    .i2c_sda          (i2c_sda),
    .i2c_scl          (i2c_scl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int low_cyc, pulses, acks, nrise, total_pulses;
  logic ready_n1, timed_out;
  logic [31:0] rbits;
  logic [7:0] model_stored = '0;
  logic [7:0] model_dout = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one request and decodes the bus: SDA value at every SCL rise, ack
  // intervals, receive pulses and the number of clocks ready stays low.
  task automatic txn(input logic [6:0] a, input logic [7:0] d, input logic r, input int hold);
    logic prev_scl, prev_ack, done;
    int n;
    low_cyc = 0; pulses = 0; acks = 0; nrise = 0; rbits = '0;
    timed_out = 1'b0; ready_n1 = 1'b1;
    @(negedge clk);
    addr = a; data_in = d; rw = r; enable = 1'b1;
    prev_scl = i2c_scl; prev_ack = ack;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n >= hold) enable = 1'b0;
      if (n == 1) ready_n1 = ready;
      if (!ready) low_cyc++;
      if (new_byte_received) pulses++;
      if (ack && !prev_ack) acks++;
      if (i2c_scl && !prev_scl) begin
        if (nrise < 32) rbits[nrise] = i2c_sda;
        nrise++;
      end
      prev_scl = i2c_scl; prev_ack = ack;
      if (ready && low_cyc > 0) done = 1'b1;
      if (n > 400) begin done = 1'b1; timed_out = 1'b1; end
    end
    enable = 1'b0;
    total_pulses += pulses;
  endtask

  task automatic verify(input logic [6:0] a, input logic [7:0] d, input logic r);
    logic match;
    logic [7:0] abyte, dbyte;
    match = (a == SLV);
    check("timeout", 32'(timed_out), 32'd0);
    check("busy_clks", 32'(low_cyc), match ? 32'(20 * 2 * HP) : 32'(11 * 2 * HP));
    check("scl_rises", 32'(nrise), match ? 32'd18 : 32'd9);
    abyte = '0;
    for (int i = 0; i < 8; i++) abyte = {abyte[6:0], rbits[i]};
    check("addr_byte", 32'(abyte), 32'({a, r}));
    check("addr_ack_bit", 32'(rbits[8]), 32'(!match));
    check("ack_bits", 32'(acks), match ? (r ? 32'd1 : 32'd2) : 32'd0);
    check("pulses", 32'(pulses), (match && !r) ? 32'd1 : 32'd0);
    if (match) begin
      if (r) model_dout = model_stored;
      else model_stored = d;
      dbyte = '0;
      for (int i = 9; i < 17; i++) dbyte = {dbyte[6:0], rbits[i]};
      check("data_byte", 32'(dbyte), r ? 32'(model_stored) : 32'(d));
      check("final_bit", 32'(rbits[17]), 32'(r));
    end
    check("rx_data", 32'(rx_data), 32'(model_stored));
    check("data_out", 32'(data_out), 32'(model_dout));
    check("bus_idle", 32'({i2c_scl, i2c_sda}), 32'd3);
  endtask

  initial begin
    logic [6:0] ra;
    logic [7:0] rd;
    logic rr;
    total_pulses = 0;
    #100 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sda", 32'(i2c_sda), 32'd1);
    check("rst_scl", 32'(i2c_scl), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);

    txn(SLV, 8'h06, 1'b0, 5);
    check("ready_drop", 32'(ready_n1), 32'd0);
    verify(SLV, 8'h06, 1'b0);

    total_pulses = 0;
    for (int k = 0; k < 100; k++) begin
      txn(SLV, 8'(8'h07 + k), 1'b0, 1);
      verify(SLV, 8'(8'h07 + k), 1'b0);
    end
    check("pulse_total", 32'(total_pulses), 32'd100);

    txn(7'h2B, 8'hC3, 1'b0, 1);
    verify(7'h2B, 8'hC3, 1'b0);

    txn(SLV, 8'h5A, 1'b0, 1);
    verify(SLV, 8'h5A, 1'b0);
    txn(SLV, 8'h00, 1'b1, 1);
    verify(SLV, 8'h00, 1'b1);

    @(negedge clk);
    addr = SLV; data_in = 8'h33; rw = 1'b0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (48) @(negedge clk);
    check("mid_busy", 32'(ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_bus", 32'({i2c_scl, i2c_sda}), 32'd3);
    check("arst_rx_data", 32'(rx_data), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    check("arst_pulse", 32'(new_byte_received), 32'd0);
    model_stored = '0;
    model_dout = '0;
    @(negedge clk);
    rst = 1'b0;
    txn(SLV, 8'h00, 1'b1, 1);
    verify(SLV, 8'h00, 1'b1);
    txn(SLV, 8'h11, 1'b0, 1);
    verify(SLV, 8'h11, 1'b0);

    for (int k = 0; k < 30; k++) begin
      ra = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom);
      rd = 8'($urandom);
      rr = 1'($urandom_range(0, 1));
      txn(ra, rd, rr, $urandom_range(1, 6));
      verify(ra, rd, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_slave_pair.md
Name: i2c_master_slave_pair

Overview:
Self-contained I2C link: a byte-oriented I2C master FSM and an addressed I2C slave share one internal open-drain SDA/SCL bus. The host side requests single-byte write or read transactions to a 7-bit address. The slave stores written bytes and returns its last stored byte on reads. The resolved bus lines are exported for observation. Used as a loopback/verification vehicle for I2C protocol logic.

Parameters:
HALF_PERIOD, 2, system clocks per SCL half period (SCL period = 2*HALF_PERIOD clks); legal values >= 2.

Ports:
clk  input  1  system clock; all logic is clocked on its rising edge.
rst  input  1  reset; one clock, rst is asynchronous and active-high.
addr  input  7  target slave address, sampled with enable.
data_in  input  8  byte to write, sampled with enable.
rw  input  1  0 = write, 1 = read; sampled with enable.
enable  input  1  transaction request level/pulse; honoured only while ready=1.
slave_addr  input  7  address the slave responds to; static.
data_out  output  8  byte captured by the master on a read.
ready  output  1  1 = master idle, request accepted.
rx_data  output  8  last byte written into the slave.
new_byte_received  output  1  one-clk pulse when the slave completes a written data byte.
ack  output  1  high while the slave drives an ACK bit.
i2c_sda  output  1  resolved SDA (wired-AND of master and slave pull-downs, idle 1).
i2c_scl  output  1  SCL driven by master, idle 1.

Behaviour:
- Reset: all FSMs to IDLE; data_out=0, rx_data=0, new_byte_received=0, ack=0, ready=1, SCL=1, SDA released (1); slave stored byte=0.
- Timing: every master state except IDLE lasts exactly one SCL period (2*HALF_PERIOD clks). In bit states SCL is low for the first half and high for the second. SDA changes only at period start (SCL low).
- Master states: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP.
- IDLE: ready=1. enable=1 on any clk latches addr/data_in/rw; ready drops the next cycle; then START.
- START: SCL high throughout; SDA falls at the midpoint.
- ADDR: 8 bits {addr,rw}, MSB first, one period per bit.
- ADDR_ACK: master releases SDA and samples at SCL rising edge. ACK (0) goes to WR_DATA or RD_DATA per rw; NACK (1) goes to STOP.
- WR_DATA: 8 bits data_in MSB first, then WR_ACK (ACK sampled, either value), then STOP.
- RD_DATA: master releases SDA and shifts SDA in at each SCL rise, MSB first. data_out is updated after bit 0. Then RD_NACK (master leaves SDA high), then STOP.
- STOP: SCL high whole period; SDA low first half, rises at the midpoint; then IDLE.
- Duration: write 20 SCL periods, read 20, address NACK 11 (80/80/44 clks at default).
- enable while busy is ignored. rst mid-transaction aborts immediately to reset state.
- Slave samples i2c_sda/i2c_scl with clk and uses edge detection (no SCL-clocked flops).
  - START = SDA fall while SCL high: restarts in RECV_ADDR from any state.
  - STOP = SDA rise while SCL high: returns to IDLE.
  - Bits are sampled on SCL rise and driven after SCL fall.
- Slave states: IDLE, RECV_ADDR, ADDR_ACK, RECV_DATA, DATA_ACK, SEND_DATA, WAIT_MACK.
- Address bits 7:1 == slave_addr: drive ACK (SDA low, ack=1) for the ACK bit period, then RECV_DATA (rw=0) or SEND_DATA (rw=1). Mismatch: release SDA and return to IDLE.
- RECV_DATA: after the 8th bit, rx_data and stored byte are updated and new_byte_received pulses one clk; then DATA_ACK drives ACK.
- SEND_DATA: drives the stored byte MSB first, then WAIT_MACK, then IDLE.

Decomposition:
- Shared package i2c_pkg: master/slave state enums, bit-counter width (3 bits), SDA idle constant.
- Sub-module i2c_slave_ctrl instantiated inside the top.
- Master FSM and clock divider live in the top.
- Bus resolution is a continuous AND in the top.

Test Plan:
- Reset held 100 ns, then release -> ready=1, i2c_sda=1, i2c_scl=1, rx_data=0, data_out=0.
- slave_addr=0x2A; write addr=0x2A, data_in=0x06, enable for 5 clks -> ready low next clk; ack high in both ACK bits; rx_data=0x06; one new_byte_received pulse; ready high after 80 clks.
- 100 back-to-back writes, data_in incremented each time ready rises (0x07..0x6A) -> rx_data tracks each value; exactly 100 pulses; no stuck bus.
- Write addr=0x2B -> no ack, rx_data unchanged, no pulse; STOP issued; ready back after 44 clks.
- After writing 0x5A, read addr=0x2A, rw=1 -> data_out=0x5A; master NACK seen on bus; STOP; ready=1.
- Assert rst during the data byte -> all outputs return to reset values asynchronously; the next write of 0x11 completes normally with rx_data=0x11.
